dram_word_port: RTL and testbench

Initiator-side bridge between a single 32-bit word requester and the 128-bit DRAM user interface (`i_ren`/`i_wen`/`i_addr`/`i_data`/`i_mask`/`i_busy` in, `o_data`/`o_data_valid`/`o_busy`/`o_init_calib_complete` out). It runs in the DRAM user clock domain (`o_clk`/`o_rst`). It accepts one word read or write at a time, widens writes into a masked 128-bit beat, issues a single DRAM command, and extracts the addressed word from the returned beat. It sits between the core's memory arbiter and the DRAM wrapper.

---
 rtl/dram_word_port.sv | 156 +++++++++++++++
 tb/tb_dram_word_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_word_port.sv
// Word-to-beat bridge between a 32-bit requester and the 128-bit DRAM user interface.
// Optional one-beat read line buffer enabled by defining DRAM_WORD_PORT_LINE_BUF_EN.
//
// state  | meaning
// CALIB  | waiting for DRAM calibration
// IDLE   | ready for a request
// ISSUE  | presenting the command until the wrapper is not busy
// RDWAIT | waiting for the read beat
// RESP   | one-cycle completion pulse
module dram_word_port #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_wstrb,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      dram_ren,
  output logic                      dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] dram_addr,
  output logic [APP_DATA_WIDTH-1:0] dram_wdata,
  output logic [APP_MASK_WIDTH-1:0] dram_wmask,
  output logic                      dram_user_busy,
  input  logic                      dram_init_calib_complete,
  input  logic [APP_DATA_WIDTH-1:0] dram_rdata,
  input  logic                      dram_rdata_valid,
  input  logic                      dram_busy
);

  typedef enum logic [2:0] {CALIB, IDLE, ISSUE, RDWAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      accept;
  logic                      buf_hit;
  logic                      wen_q;
  logic [1:0]                lane_q, lane_d;
  logic [APP_ADDR_WIDTH-2:0] addr_d;
  logic [APP_DATA_WIDTH-1:0] wdata_d;
  logic [APP_MASK_WIDTH-1:0] wmask_d;
  logic                      rd_done;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:APP_ADDR_WIDTH+3], req_addr[1:0]};

  assign lane_d  = req_addr[3:2];
  assign addr_d  = req_addr[APP_ADDR_WIDTH+2:4];
  assign wdata_d = {4{req_wdata}};
  assign wmask_d = ~({12'b0, req_wstrb} << {lane_d, 2'b00});
  assign rd_done = (state_q == RDWAIT) && dram_rdata_valid;

`ifdef DRAM_WORD_PORT_LINE_BUF_EN
  logic                      buf_valid;
  logic [APP_ADDR_WIDTH-2:0] buf_tag;
  logic [APP_DATA_WIDTH-1:0] buf_data;

  assign buf_hit = !req_wen && buf_valid && (buf_tag == addr_d);

  // Buffer always mirrors DRAM: filled by read beats, write-through merges strobed bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state_q == CALIB) begin
      buf_valid <= 1'b0;
    end else if (rd_done) begin
      buf_valid <= 1'b1;
      buf_tag   <= dram_addr;
      buf_data  <= dram_rdata;
    end else if (accept && req_wen && buf_valid && (buf_tag == addr_d)) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!wmask_d[b]) buf_data[8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    dram_ren       = 1'b0;
    dram_wen       = 1'b0;
    dram_user_busy = 1'b1;
    case (state_q)
      CALIB: if (dram_init_calib_complete) state_d = IDLE;
      IDLE: begin
        if (!dram_init_calib_complete) begin
          state_d = CALIB;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            accept  = 1'b1;
            state_d = buf_hit ? RESP : ISSUE;
          end
        end
      end
      ISSUE: begin
        dram_ren = !wen_q && !dram_busy;
        dram_wen = wen_q && !dram_busy;
        if (!dram_busy) state_d = wen_q ? RESP : RDWAIT;
      end
      RDWAIT: begin
        dram_user_busy = 1'b0;
        if (dram_rdata_valid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = CALIB;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= CALIB;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wen_q      <= 1'b0;
      lane_q     <= 2'd0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wmask <= '1;
      resp_rdata <= 32'd0;
    end else begin
      if (accept) begin
        wen_q      <= req_wen;
        lane_q     <= lane_d;
        dram_addr  <= addr_d;
        dram_wdata <= wdata_d;
        dram_wmask <= wmask_d;
      end
      if (rd_done) begin
        resp_rdata <= dram_rdata[{lane_q, 5'd0} +: 32];
`ifdef DRAM_WORD_PORT_LINE_BUF_EN
      end else if (accept && buf_hit) begin
        resp_rdata <= buf_data[{lane_d, 5'd0} +: 32];
`endif
      end
    end
  end

endmodule

// File: tb/tb_dram_word_port.sv
// Randomised self-checking bench for dram_word_port against a transaction-level model.
// Define DRAM_WORD_PORT_LINE_BUF_EN to also exercise the line buffer.
module tb_dram_word_port;

`ifdef DRAM_WORD_PORT_LINE_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_wen;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_wstrb;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         dram_ren, dram_wen;
  logic [26:0]  dram_addr;
  logic [127:0] dram_wdata;
  logic [15:0]  dram_wmask;
  logic         dram_user_busy, dram_init_calib_complete;
  logic [127:0] dram_rdata;
  logic         dram_rdata_valid, dram_busy;

  always #5 clock = ~clock;

  dram_word_port dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wmask(dram_wmask),
    .dram_user_busy(dram_user_busy),
    .dram_init_calib_complete(dram_init_calib_complete),
    .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid),
    .dram_busy(dram_busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, set by the transaction model.
  logic         exp_ready, exp_resp, exp_ren, exp_wen, exp_ubusy;
  logic [31:0]  exp_rdata;
  logic [26:0]  exp_addr;
  logic [127:0] exp_wdata;
  logic [15:0]  exp_wmask;

  logic [127:0] mem [logic [26:0]];
  bit           buf_valid_m = 1'b0;
  logic [26:0]  buf_tag_m = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] beat_of(input logic [26:0] k);
    if (!mem.exists(k)) mem[k] = rand128();
    return mem[k];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [26:0] k;
    k = 27'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) k[26] = 1'b1;
    return {1'($urandom), k, 2'($urandom), 2'($urandom)};
  endfunction

  task automatic set_reset_exp();
    exp_ready = 0; exp_resp = 0; exp_ren = 0; exp_wen = 0; exp_ubusy = 1;
    exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_wmask = 16'hFFFF;
  endtask

  always @(negedge clock) begin
    if (dram_ren) ren_cnt++;
    if (dram_wen) wen_cnt++;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("req_ready", 128'(req_ready), 128'(exp_ready));
      chk("resp_valid", 128'(resp_valid), 128'(exp_resp));
      chk("dram_ren", 128'(dram_ren), 128'(exp_ren));
      chk("dram_wen", 128'(dram_wen), 128'(exp_wen));
      chk("dram_user_busy", 128'(dram_user_busy), 128'(exp_ubusy));
      chk("resp_rdata", 128'(resp_rdata), 128'(exp_rdata));
      chk("dram_addr", 128'(dram_addr), 128'(exp_addr));
      chk("dram_wdata", dram_wdata, exp_wdata);
      chk("dram_wmask", 128'(dram_wmask), 128'(exp_wmask));
    end
  end

  // Runs one request starting in an IDLE cycle; returns in the following IDLE cycle.
  task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int busy, input int dly, input bit abort);
    logic [26:0]  key;
    logic [1:0]   lane;
    logic [127:0] beat;
    bit           hit;
    key  = addr[30:4];
    lane = addr[3:2];
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    dram_busy = 1'($urandom); dram_rdata_valid = 1'($urandom); dram_rdata = rand128();
    exp_ready = 1; exp_resp = 0; exp_ren = 0; exp_wen = 0; exp_ubusy = 1;
    step();
    hit = BUF && !wen && buf_valid_m && (buf_tag_m == key);
    req_valid = 0; req_wen = 1'($urandom); req_addr = $urandom(); req_wdata = $urandom();
    req_wstrb = 4'($urandom);
    exp_ready = 0;
    exp_addr  = key;
    exp_wdata = {4{wdata}};
    exp_wmask = 16'(~(16'(strb) << (4 * int'(lane))));
    if (hit) begin
      beat = beat_of(key);
      exp_resp = 1;
      exp_rdata = beat[32*lane +: 32];
      step();
      exp_resp = 0; exp_ready = 1;
      return;
    end
    for (int i = 0; i < busy; i++) begin
      dram_busy = 1; dram_rdata_valid = 1'($urandom);
      step();
    end
    dram_busy = 0; dram_rdata_valid = 1'($urandom);
    exp_ren = !wen; exp_wen = wen;
    step();
    exp_ren = 0; exp_wen = 0; dram_busy = 1'($urandom);
    if (wen) begin
      beat = beat_of(key);
      for (int b = 0; b < 4; b++)
        if (strb[b]) beat[32*lane + 8*b +: 8] = wdata[8*b +: 8];
      mem[key] = beat;
      exp_resp = 1; dram_rdata_valid = 1'($urandom);
      step();
    end else begin
      dram_rdata_valid = 0; exp_ubusy = 0;
      for (int i = 0; i < dly; i++) step();
      if (abort) begin
        reset = 1;
        set_reset_exp();
        buf_valid_m = 0;
        step();
        step();
        reset = 0;
        dram_rdata_valid = 1; dram_rdata = beat_of(key);
        step();
        dram_rdata_valid = 0;
        exp_ready = 1;
        return;
      end
      beat = beat_of(key);
      dram_rdata_valid = 1; dram_rdata = beat;
      step();
      dram_rdata_valid = 0; dram_rdata = rand128();
      exp_ubusy = 1; exp_resp = 1; exp_rdata = beat[32*lane +: 32];
      if (BUF) begin
        buf_valid_m = 1; buf_tag_m = key;
      end
      step();
    end
    exp_resp = 0; exp_ready = 1; dram_rdata_valid = 0;
  endtask

  task automatic calib_drop();
    req_valid = 0;
    dram_init_calib_complete = 0; exp_ready = 0;
    step();
    step();
    dram_init_calib_complete = 1;
    buf_valid_m = 0;
    step();
    exp_ready = 1;
  endtask

  int r0, w0;
  logic [31:0] saved;

  initial begin
    reset = 1; dram_init_calib_complete = 0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    dram_rdata = '0; dram_rdata_valid = 0; dram_busy = 0;
    set_reset_exp();
    repeat (2) step();
    chk("rst_req_ready", 128'(req_ready), 128'(1'b0));
    chk("rst_user_busy", 128'(dram_user_busy), 128'(1'b1));
    chk("rst_wmask", 128'(dram_wmask), 128'(16'hFFFF));
    chk("rst_rdata", 128'(resp_rdata), 128'(32'h0));
    reset = 0;
    chk_en = 1;

    // Calibration gate with a pending request.
    req_valid = 1; req_wen = 1; req_addr = 32'h40; req_wdata = 32'h1; req_wstrb = 4'hF;
    r0 = ren_cnt; w0 = wen_cnt;
    repeat (50) step();
    chk("calib_gate_cmds", 128'((ren_cnt - r0) + (wen_cnt - w0)), 128'(0));
    dram_init_calib_complete = 1;
    step();

    // Write to lane 2 accepted in the first ready cycle.
    w0 = wen_cnt;
    do_txn(1'b1, 32'h0000_1238, 32'hA5A5_1234, 4'b0011, 0, 0, 1'b0);
    chk("wr_lane2_addr", 128'(dram_addr), 128'(27'h123));
    chk("wr_lane2_wmask", 128'(dram_wmask), 128'(16'hFCFF));
    chk("wr_lane2_wdata", dram_wdata, {4{32'hA5A5_1234}});
    chk("wr_lane2_wen_pulses", 128'(wen_cnt - w0), 128'(1));

    // Read with three busy cycles.
    mem[27'h104] = {{4{8'h44}}, {4{8'h33}}, {4{8'h22}}, {4{8'h11}}};
    r0 = ren_cnt;
    do_txn(1'b0, 32'h0000_104C, 32'h0, 4'h0, 3, 2, 1'b0);
    chk("rd_busy_rdata", 128'(resp_rdata), 128'(32'h4444_4444));
    chk("rd_busy_ren_pulses", 128'(ren_cnt - r0), 128'(1));

    // Stray read data in IDLE.
    saved = resp_rdata;
    dram_rdata_valid = 1; dram_rdata = rand128();
    step();
    dram_rdata_valid = 0;
    step();
    chk("stray_rdata_held", 128'(resp_rdata), 128'(saved));

    if (BUF) begin
      r0 = ren_cnt;
      do_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1, 1'b0);
      do_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 1'b0);
      chk("buf_hit_ren_pulses", 128'(ren_cnt - r0), 128'(1));
      do_txn(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4'hF, 1, 0, 1'b0);
      do_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 1'b0);
      chk("buf_merge_rdata", 128'(resp_rdata), 128'(32'hDEAD_BEEF));
      chk("buf_merge_ren_pulses", 128'(ren_cnt - r0), 128'(1));
    end

    // Reset while waiting for read data.
    do_txn(1'b0, 32'h0000_0074, 32'h0, 4'h0, 1, 1, 1'b1);
    chk("abort_rdata", 128'(resp_rdata), 128'(32'h0));
    chk("abort_wmask", 128'(dram_wmask), 128'(16'hFFFF));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) calib_drop();
      do_txn(1'($urandom), rand_addr(), $urandom(), 4'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 24) == 0);
    end

    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
